// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: consumes keypad scanner strobes, builds a BCD entry buffer,
// clears it on '*', commits it on '#', and drives a piezo tone burst for
// every accepted or rejected key.
module key_entry_ctrl #(
    parameter int DIGITS      = 4,
    parameter int BEEP_CYCLES = 1_637_500,
    parameter int TONE_DIV    = 3275
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            key_value,
    input  logic                  key_number,
    input  logic                  key_star,
    input  logic                  key_sharp,
    output logic [4*DIGITS-1:0]   entry_digits,
    output logic [2:0]            digit_count,
    output logic [4*DIGITS-1:0]   entry_value,
    output logic                  entry_valid,
    output logic                  overflow,
    output logic                  buzz_out
);

    localparam int BUF_W  = 4 * DIGITS;
    localparam int BEEP_W = $clog2(2 * BEEP_CYCLES + 1);
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    localparam logic [2:0]        FULL_COUNT  = 3'(DIGITS);
    localparam logic [BEEP_W-1:0] SHORT_LEN   = BEEP_W'(BEEP_CYCLES);
    localparam logic [BEEP_W-1:0] ERROR_LEN   = BEEP_W'(2 * BEEP_CYCLES);
    localparam logic [TONE_W-1:0] TONE_RELOAD = TONE_W'(TONE_DIV - 1);

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        FULL
    } state_t;

    // Strobe bit order everywhere: [0] digit/unused, [1] star, [2] sharp.
    logic [2:0] strobeRaw;
    logic [2:0] strobeS1_q;
    logic [2:0] strobeS2_q;
    logic [2:0] strobePrev_q;
    logic [2:0] armed_q;
    logic [1:0] settle_q;
    logic [3:0] valueS1_q;
    logic [3:0] valueS2_q;
    logic [2:0] rise;

    logic       evNum_q;
    logic       evStar_q;
    logic       evSharp_q;
    logic [3:0] evValue_q;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buffer_q, buffer_d;
    logic [2:0]         count_q, count_d;
    logic [BUF_W-1:0]   value_q, value_d;
    logic               valid_q, valid_d;
    logic               overflow_q, overflow_d;
    logic               beepShort;
    logic               beepError;

    logic [BEEP_W-1:0]  beepCount_q;
    logic [TONE_W-1:0]  toneCount_q;
    logic               buzz_q;

    assign strobeRaw = {key_sharp, key_star, key_number};

    // A strobe only counts as rising once it has been seen low after reset,
    // so a key held through reset release never produces an event.
    assign rise = strobeS2_q & ~strobePrev_q & armed_q;

    // Two-flop synchronisers, edge register and post-reset arming.
    always_ff @(posedge clk) begin
        if (reset) begin
            strobeS1_q   <= '0;
            strobeS2_q   <= '0;
            strobePrev_q <= '0;
            armed_q      <= '0;
            settle_q     <= '0;
            valueS1_q    <= '0;
            valueS2_q    <= '0;
        end else begin
            strobeS1_q   <= strobeRaw;
            strobeS2_q   <= strobeS1_q;
            strobePrev_q <= strobeS2_q;
            valueS1_q    <= key_value;
            valueS2_q    <= valueS1_q;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            armed_q      <= armed_q | ({3{settle_q == 2'd2}} & ~strobeS2_q);
        end
    end

    // Register one prioritised event per cycle: '#' over '*' over digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            evNum_q   <= 1'b0;
            evStar_q  <= 1'b0;
            evSharp_q <= 1'b0;
            evValue_q <= '0;
        end else begin
            evSharp_q <= rise[2];
            evStar_q  <= rise[1] & ~rise[2];
            evNum_q   <= rise[0] & ~rise[1] & ~rise[2];
            evValue_q <= valueS2_q;
        end
    end

    // Entry FSM next-state, buffer update and beep requests.
    always_comb begin
        state_d    = state_q;
        buffer_d   = buffer_q;
        count_d    = count_q;
        value_d    = value_q;
        valid_d    = 1'b0;
        overflow_d = 1'b0;
        beepShort  = 1'b0;
        beepError  = 1'b0;

        if (evSharp_q) begin
            if (state_q != EMPTY) begin
                value_d   = buffer_q;
                valid_d   = 1'b1;
                buffer_d  = '0;
                count_d   = '0;
                state_d   = EMPTY;
                beepShort = 1'b1;
            end else begin
                beepError = 1'b1;
            end
        end else if (evStar_q) begin
            buffer_d  = '0;
            count_d   = '0;
            state_d   = EMPTY;
            beepShort = 1'b1;
        end else if (evNum_q && (evValue_q <= 4'd9)) begin
            if (state_q == FULL) begin
                overflow_d = 1'b1;
                beepError  = 1'b1;
            end else begin
                buffer_d       = buffer_q << 4;
                buffer_d[3:0]  = evValue_q;
                count_d        = count_q + 3'd1;
                state_d        = (count_d == FULL_COUNT) ? FULL : ENTRY;
                beepShort      = 1'b1;
            end
        end
    end

    // Entry FSM state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            buffer_q   <= '0;
            count_q    <= '0;
            value_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buffer_q   <= buffer_d;
            count_q    <= count_d;
            value_q    <= value_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Beep generator: a new request restarts length and tone phase, high first.
    always_ff @(posedge clk) begin
        if (reset) begin
            beepCount_q <= '0;
            toneCount_q <= '0;
            buzz_q      <= 1'b0;
        end else if (beepShort || beepError) begin
            beepCount_q <= beepError ? ERROR_LEN : SHORT_LEN;
            toneCount_q <= TONE_RELOAD;
            buzz_q      <= 1'b1;
        end else if (beepCount_q > BEEP_W'(1)) begin
            beepCount_q <= beepCount_q - BEEP_W'(1);
            if (toneCount_q == '0) begin
                toneCount_q <= TONE_RELOAD;
                buzz_q      <= ~buzz_q;
            end else begin
                toneCount_q <= toneCount_q - TONE_W'(1);
            end
        end else begin
            beepCount_q <= '0;
            buzz_q      <= 1'b0;
        end
    end

    assign entry_digits = buffer_q;
    assign digit_count  = count_q;
    assign entry_value  = value_q;
    assign entry_valid  = valid_q;
    assign overflow     = overflow_q;
    assign buzz_out     = buzz_q;

endmodule
